// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier for unsigned or two's-complement operands.
// One operation takes WIDTH+2 cycles from the accepted START to the next possible START.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               SGN,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               BUSY,
  output logic               DONE,
  output logic [1:0]         STATE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] p_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic [2*WIDTH-1:0] prod_d;

  // Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) begin
      return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end
    return v;
  endfunction

  always_comb begin
    mag_a_d = magnitude(A, SGN);
    mag_b_d = magnitude(B, SGN);
    prod_d  = neg_q ? ((~acc_q) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            neg_q    <= SGN & (A[WIDTH-1] ^ B[WIDTH-1]);
            mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mplier_q <= mplier_q >> 1;
          mcand_q  <= mcand_q << 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          p_q     <= prod_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign P     = p_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=4 and WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst;
  logic       start4, sgn4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       busy4, done4;
  logic [1:0] state4;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        busy8, done8;
  logic [1:0]  state8;

  int n_checks = 0;
  int n_errors = 0;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .SGN(sgn4), .A(a4), .B(b4),
    .P(p4), .BUSY(busy4), .DONE(done4), .STATE(state4)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .SGN(sgn8), .A(a8), .B(b8),
    .P(p8), .BUSY(busy8), .DONE(done8), .STATE(state8)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives START with the operands, then follows the operation to its DONE edge.
  // With noise set, START is held high with other operands throughout the busy window.
  // Leaves START as-is on return so a caller can chain the next request back to back.
  task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b,
                     input logic noise, input logic [7:0] exp);
    sgn4 = s; a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k <= 4; k++) begin
      check("busy4_run", busy4, 1);
      check("done4_run", done4, 0);
      if (noise) begin
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; sgn4 = ~s;
      end else begin
        start4 = 1'b0; a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
        sgn4 = 1'($urandom_range(0, 1));
      end
      @(posedge clk); @(negedge clk);
    end
    check("done4_fin", done4, 1);
    check("busy4_fin", busy4, 0);
    check("p4", p4, exp);
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    sgn8 = s; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    for (int k = 0; k <= 8; k++) begin
      check("busy8_run", busy8, 1);
      check("done8_run", done8, 0);
      @(posedge clk); @(negedge clk);
    end
    check("done8_fin", done8, 1);
    check("busy8_fin", busy8, 0);
    check("p8", p8, exp);
    @(posedge clk); @(negedge clk);
    check("done8_pulse", done8, 0);
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    #2;
    check("rst_p4", p4, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_state4", state4, 0);
    check("rst_p8", p8, 0);
    @(negedge clk);
    rst = 1'b0;

    // first START right after reset release must be accepted
    op4(1'b0, 4'd15, 4'd15, 1'b0, 8'hE1);
    op4(1'b1, 4'h8, 4'h8, 1'b0, 8'h40);
    op4(1'b1, 4'h8, 4'h7, 1'b0, 8'hC8);
    op4(1'b0, 4'h8, 4'h7, 1'b0, 8'h38);
    op4(1'b1, 4'hF, 4'h1, 1'b0, 8'hFF);
    op4(1'b1, 4'h0, 4'h8, 1'b0, 8'h00);
    op4(1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    op4(1'b1, 4'h7, 4'h7, 1'b0, 8'h31);
    op4(1'b0, 4'd3, 4'd5, 1'b1, 8'h0F);
    start4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      check("no_second_done", done4, 0);
      check("p4_hold", p4, 8'h0F);
    end

    // abort mid-operation with an asynchronous reset pulse
    sgn4 = 1'b0; a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("pre_abort_busy", busy4, 1);
    rst = 1'b1;
    #1;
    check("abort_p4", p4, 0);
    check("abort_busy4", busy4, 0);
    check("abort_done4", done4, 0);
    check("abort_state4", state4, 0);
    #1 rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); @(negedge clk);
      check("abort_no_done", done4, 0);
      check("abort_p4_hold", p4, 0);
    end
    op4(1'b0, 4'd2, 4'd6, 1'b0, 8'd12);

    // exhaustive sweep, each START chained into the first IDLE cycle
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          int ea, eb;
          logic [3:0] av, bv;
          av = 4'(a); bv = 4'(b);
          ea = (s != 0) ? int'($signed(av)) : a;
          eb = (s != 0) ? int'($signed(bv)) : b;
          op4(1'(s), av, bv, 1'b0, 8'(ea * eb));
        end
      end
    end
    start4 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("exh_done_pulse", done4, 0);

    op8(1'b1, 8'h80, 8'h80, 16'h4000);
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8(1'b1, 8'h80, 8'h7F, 16'hC080);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port START  input  1  request to begin a multiply; sampled on rising CLK.
REQ-005 SHALL have port SGN  input  1  mode: 0 = unsigned operands, 1 = two's-complement operands; sampled with START.
REQ-006 SHALL have port A  input  WIDTH  multiplicand; sampled with START.
REQ-007 SHALL have port B  input  WIDTH  multiplier; sampled with START.
REQ-008 SHALL have port P  output  2*WIDTH  registered product.
REQ-009 SHALL have port BUSY  output  1  high while an operation is in progress (states LOAD-accepted through DONE).
REQ-010 SHALL have port DONE  output  1  one-cycle pulse marking P updated with a new result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIN; reset state IDLE.
REQ-012 IDLE: START=1 at rising edge SHALL latch SGN, |A| and |B| magnitudes (magnitude = two's-complement negate when SGN=1 and MSB=1, else raw), result sign = SGN & (A[MSB] ^ B[MSB]), clear accumulator and step counter, go to CALC.
REQ-013 CALC: each cycle SHALL add shifted multiplicand to accumulator when current multiplier LSB=1, shift multiplier right 1 and multiplicand left 1, increment counter; exactly WIDTH CALC cycles, then go to FIN.
REQ-014 FIN: SHALL load P with accumulator (negated in 2*WIDTH bits when result sign=1), assert DONE for that one cycle, return to IDLE unconditionally.
REQ-015 Latency: START sampled at edge n SHALL yield P and DONE=1 at edge n+WIDTH+1; fixed, independent of operand values.
REQ-016 BUSY SHALL be 1 from edge n through edge n+WIDTH+1 (CALC and FIN), 0 in IDLE.
REQ-017 START while BUSY=1 (CALC or FIN) SHALL be ignored; no queueing; A/B/SGN changes during operation SHALL not affect the result.
REQ-018 Earliest next START SHALL be accepted at edge n+WIDTH+2 (first IDLE cycle after FIN); back-to-back operations therefore run every WIDTH+2 cycles.
REQ-019 P SHALL hold its last value between results; it changes only in FIN or reset.
REQ-020 Accumulator SHALL be 2*WIDTH bits; unsigned product of two WIDTH-bit values and signed product including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2) SHALL fit without overflow.
REQ-021 Magnitude of -2^(WIDTH-1) SHALL be held as unsigned WIDTH-bit value 2^(WIDTH-1) (no truncation error).
REQ-022 Zero operand SHALL still take full latency and produce P=0 (no negative zero issue; negate of 0 is 0).
REQ-023 DONE SHALL never be high for more than one consecutive cycle.

Reset
REQ-024 RST=1 SHALL immediately (without clock) force state IDLE, P=0, BUSY=0, DONE=0, accumulator, operand registers and counter to 0.
REQ-025 RST asserted mid-operation SHALL abort it; no DONE pulse and no P update for the aborted operation.
REQ-026 After RST deasserts, first START SHALL be accepted at the first rising CLK edge where RST=0.

Verification
REQ-027 WIDTH=4, SGN=0, A=15, B=15, START at edge 0 -> BUSY=1 edges 0..5, DONE=1 and P=8'hE1 (225) at edge 5, IDLE at edge 6.
REQ-028 WIDTH=4, SGN=1, A=4'h8 (-8), B=4'h8 (-8) -> P=8'h40 (64) at edge 5; SGN=1, A=-8, B=7 -> P=8'hC8 (-56); SGN=0, A=4'h8, B=4'h7 -> P=8'h38 (56).
REQ-029 WIDTH=4: START A=3,B=5, then at edge 2 START A=9,B=9 -> second request ignored, P=15 at edge 5, no second DONE.
REQ-030 WIDTH=4: START A=13,B=11 at edge 0, RST pulse between edges 2 and 3 -> P=0, BUSY=0, no DONE; then START A=2,B=6 -> P=12 five edges later.
REQ-031 WIDTH=4 exhaustive: all 256 A/B pairs in both SGN modes, START re-issued at each first IDLE cycle (every 6 cycles) -> every P matches reference product, exactly one DONE per operation.
REQ-032 WIDTH=8: SGN=1, A=8'h80, B=8'h80 -> P=16'h4000 at edge 9; SGN=0, A=8'hFF, B=8'hFF -> P=16'hFE01.
